// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the lightbike pipeline sequencer: state encodings,
// default parameter values and the nop word that flush consumers load.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_MDWAIT = 2'd2
   } state_t;

   localparam int DEF_REG_W       = 5;
   localparam int DEF_BOOT_CYCLES = 2;
   localparam int DEF_MD_TIMEOUT  = 40;
   localparam int DEF_CNT_W       = 16;

   // Flushed F/D and D/X registers are loaded with this all-zero word.
   localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector between the D/X load and the F/D consumer.
// Also instanced by the forwarding unit.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             dx_is_load,
   input  logic [REG_W-1:0] dx_rd,
   input  logic [REG_W-1:0] fd_rs,
   input  logic [REG_W-1:0] fd_rt,
   input  logic             fd_uses_rs,
   input  logic             fd_uses_rt,
   output logic             load_use
);

   logic w_rs_hit;
   logic w_rt_hit;

   assign w_rs_hit = fd_uses_rs && (fd_rs == dx_rd);
   assign w_rt_hit = fd_uses_rt && (fd_rt == dx_rd);

   // r0 is hardwired to zero, so a load targeting it never produces data.
   assign load_use = dx_is_load && (dx_rd != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: boot hold, load-use interlock, control-transfer flush,
// mult/div start/wait handshake with timeout, and a saturating stall counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W       = DEF_REG_W,
   parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
   parameter int MD_TIMEOUT  = DEF_MD_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dx_is_load,
   input  logic [REG_W-1:0] dx_rd,
   input  logic [REG_W-1:0] fd_rs,
   input  logic [REG_W-1:0] fd_rt,
   input  logic             fd_uses_rs,
   input  logic             fd_uses_rt,
   input  logic             dx_is_md,
   input  logic             md_ready,
   input  logic             redirect,
   output logic             pc_stall,
   output logic             fd_stall,
   output logic             dx_bubble,
   output logic             flush_fd,
   output logic             flush_dx,
   output logic             md_start,
   output logic             md_done,
   output logic             md_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
   localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_boot_cnt;
   logic [7:0]       r_md_timer;
   logic             r_md_err;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_load_use;
   logic             w_md_timeout;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .dx_is_load (dx_is_load),
      .dx_rd      (dx_rd),
      .fd_rs      (fd_rs),
      .fd_rt      (fd_rt),
      .fd_uses_rs (fd_uses_rs),
      .fd_uses_rt (fd_uses_rt),
      .load_use   (w_load_use)
   );

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      w_next_state = r_state;
      pc_stall     = 1'b0;
      fd_stall     = 1'b0;
      dx_bubble    = 1'b0;
      flush_fd     = 1'b0;
      flush_dx     = 1'b0;
      md_start     = 1'b0;
      md_done      = 1'b0;
      w_md_timeout = 1'b0;
      case (r_state)
         ST_BOOT: begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            flush_fd = 1'b1;
            flush_dx = 1'b1;
            if (r_boot_cnt == BOOT_LAST) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (redirect) begin
               flush_fd = 1'b1;
               flush_dx = 1'b1;
            end else if (w_load_use) begin
               pc_stall  = 1'b1;
               fd_stall  = 1'b1;
               dx_bubble = 1'b1;
            end else if (dx_is_md) begin
               md_start     = 1'b1;
               w_next_state = ST_MDWAIT;
            end
         end
         ST_MDWAIT: begin
            // D/X keeps the mult/div instruction until its result is written back.
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            if (md_ready) begin
               md_done      = 1'b1;
               w_next_state = ST_RUN;
            end else if (r_md_timer == MD_LAST) begin
               w_md_timeout = 1'b1;
               w_next_state = ST_RUN;
            end
         end
         default: begin
            pc_stall     = 1'b1;
            fd_stall     = 1'b1;
            flush_fd     = 1'b1;
            flush_dx     = 1'b1;
            w_next_state = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_BOOT;
         r_boot_cnt  <= '0;
         r_md_timer  <= '0;
         r_md_err    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         r_state    <= w_next_state;
         r_boot_cnt <= (r_state == ST_BOOT) ? r_boot_cnt + 4'd1 : '0;
         r_md_timer <= (r_state == ST_MDWAIT) ? r_md_timer + 8'd1 : '0;
         if (w_md_timeout) r_md_err <= 1'b1;
         if (pc_stall && (r_state == ST_RUN || r_state == ST_MDWAIT) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign md_err    = r_md_err;
   assign state     = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule
